// File: rtl/imm_compress.sv
// Inverse immediate extender: classifies a 32-bit constant into the (imm16, extOp)
// pair that regenerates it, buffered in a 2-entry FIFO with valid/ready flow control.
module imm_compress (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        clr_cnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm16,
  output logic [1:0]  out_extOp,
  output logic        out_fit,
  output logic [7:0]  miss_cnt
);

  typedef enum logic [1:0] {
    EXT_SIGN = 2'd0,
    EXT_ZERO = 2'd1,
    EXT_LUI  = 2'd2,
    EXT_NONE = 2'd3
  } ext_op_e;

  typedef struct packed {
    logic [15:0] imm16;
    ext_op_e     ext_op;
  } entry_t;

  entry_t      cls_d;
  entry_t      mem_q [2];
  entry_t      head;
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;
  logic        push, pop;

  // Fixed priority: sign wins over zero, which wins over load-upper.
  always_comb begin
    // NOTE: default first so every path assigns cls_d and no latch is inferred.
    cls_d = '{imm16: 16'h0000, ext_op: EXT_NONE};
    if ((&in_data[31:15]) || !(|in_data[31:15])) begin
      cls_d = '{imm16: in_data[15:0], ext_op: EXT_SIGN};
    end else if (!(|in_data[31:16])) begin
      cls_d = '{imm16: in_data[15:0], ext_op: EXT_ZERO};
    end else if (!(|in_data[15:0])) begin
      cls_d = '{imm16: in_data[31:16], ext_op: EXT_LUI};
    end
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (clr_cnt) begin
      miss_cnt_d = 8'd0;
    end else if (push && (cls_d.ext_op == EXT_NONE) && (miss_cnt_q != 8'hFF)) begin
      miss_cnt_d = miss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      miss_cnt_q <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // NOTE: storage is not reset; the head is masked by count, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cls_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_imm16 = out_valid ? head.imm16 : 16'h0000;
  assign out_extOp = out_valid ? head.ext_op : 2'd0;
  assign out_fit   = out_valid && (head.ext_op != EXT_NONE);
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_imm_compress.sv
// Self-checking bench for imm_compress: queue-based reference model compared every
// cycle, plus literal expectations for classification, backpressure, counter and reset.
module tb_imm_compress;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        clr_cnt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_imm16;
  logic [1:0]  out_extOp;
  logic        out_fit;
  logic [7:0]  miss_cnt;

  imm_compress dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clr_cnt   (clr_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm16 (out_imm16),
    .out_extOp (out_extOp),
    .out_fit   (out_fit),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  op;
    logic [31:0] data;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  int   model_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which extension, if any, regenerates d exactly; sign preferred, then zero, then upper.
  function automatic ent_t classify(input logic [31:0] d);
    ent_t r;
    int   s;
    s = $signed(d);
    r.data = d;
    if (s >= -32768 && s <= 32767) begin
      r.imm = d[15:0]; r.op = 2'd0;
    end else if (d <= 32'h0000_FFFF) begin
      r.imm = d[15:0]; r.op = 2'd1;
    end else if ((d % 32'd65536) == 32'd0) begin
      r.imm = 16'(d / 32'd65536); r.op = 2'd2;
    end else begin
      r.imm = 16'h0; r.op = 2'd3;
    end
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] op);
    int v;
    case (op)
      2'd0:    v = $signed(imm);
      2'd1:    v = int'(imm);
      2'd2:    v = int'(imm) * 65536;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Reference model: transfers decided from the values present at the rising edge.
  always @(posedge clk) begin
    if (reset) begin
      bit   acc, pop;
      ent_t e;
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      e   = classify(in_data);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (clr_cnt) model_miss = 0;
      else if (acc && e.op == 2'd3 && model_miss < 255) model_miss++;
    end
  end

  always @(negedge reset) begin
    q.delete();
    model_miss = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      check("in_ready", 32'(in_ready), 32'(q.size() != 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("head_imm16", 32'(out_imm16), 32'(q[0].imm));
        check("head_extOp", 32'(out_extOp), 32'(q[0].op));
        check("head_fit", 32'(out_fit), 32'(q[0].op != 2'd3));
        if (out_fit) check("reextend", extend(out_imm16, out_extOp), q[0].data);
      end else begin
        check("idle_outputs", {13'h0, out_fit, out_extOp, out_imm16}, 32'h0);
      end
      check("miss_cnt", 32'(miss_cnt), 32'(model_miss));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_check(input logic [31:0] d, input logic [15:0] imm,
                            input logic [1:0] op, input logic fit);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("cls_valid", 32'(out_valid), 32'h1);
    check("cls_imm16", 32'(out_imm16), 32'(imm));
    check("cls_extOp", 32'(out_extOp), 32'(op));
    check("cls_fit", 32'(out_fit), 32'(fit));
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0:       return x[15] ? {16'hFFFF, x[15:0]} : {16'h0000, x[15:0]};
      1:       return {16'h0000, x[15:0]};
      2:       return {x[31:16], 16'h0000};
      default: return x;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_outputs", {13'h0, out_fit, out_extOp, out_imm16}, 32'h0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
    #2 reset = 1'b1;

    // Classification
    push_check(32'h0000_0000, 16'h0000, 2'd0, 1'b1);
    push_check(32'hFFFF_8000, 16'h8000, 2'd0, 1'b1);
    push_check(32'h0000_8000, 16'h8000, 2'd1, 1'b1);
    push_check(32'hFFFF_0000, 16'hFFFF, 2'd2, 1'b1);
    push_check(32'h1234_0000, 16'h1234, 2'd2, 1'b1);
    push_check(32'h1234_5678, 16'h0000, 2'd3, 1'b0);
    check("cls_miss_cnt", 32'(miss_cnt), 32'h1);
    tick();

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0005;
    tick();
    in_data = 32'h0000_FFFF;
    tick();
    check("bp_full_ready", 32'(in_ready), 32'h0);
    in_data = 32'hABCD_0000;
    tick();
    tick();
    check("bp_held_ready", 32'(in_ready), 32'h0);
    check("bp_head_a", 32'(out_imm16), 32'h0005);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ready_after_pop", 32'(in_ready), 32'h1);
    check("bp_head_b", {14'h0, out_extOp, out_imm16}, {14'h0, 2'd1, 16'hFFFF});
    tick();
    in_valid = 1'b0;
    check("bp_refull", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    tick();
    check("bp_head_c", {14'h0, out_extOp, out_imm16}, {14'h0, 2'd2, 16'hABCD});
    tick();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Streaming
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = rand_data();
      tick();
      check("stream_valid", 32'(out_valid), 32'h1);
      check("stream_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    tick();

    // Saturating miss counter
    clr_cnt = 1'b1;
    tick();
    clr_cnt  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = ($urandom & 32'h7FFE_FFFF) | 32'h4000_0001;
      tick();
    end
    check("cnt_saturated", 32'(miss_cnt), 32'd255);
    clr_cnt = 1'b1;
    in_data = 32'h1234_5679;
    tick();
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    check("cnt_clr_priority", 32'(miss_cnt), 32'd0);
    tick();

    // Reset mid-stream with a full FIFO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    tick();
    in_data = 32'h0000_0002;
    tick();
    in_valid = 1'b0;
    check("mid_full", 32'(in_ready), 32'h0);
    check("mid_miss_before", 32'(miss_cnt), 32'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_miss", 32'(miss_cnt), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h1);
    check("mid_rst_imm16", 32'(out_imm16), 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    check("post_rst_head", {13'h0, out_fit, out_extOp, out_imm16}, {13'h0, 1'b1, 2'd0, 16'hFFFF});
    out_ready = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
